alu_arbiter: RTL and testbench

//  Shares one registered ALU between NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode, tag and round-robin helper.
// Build option ALU_ARB_PRIO0_EN (see rr_arbiter) does not change anything here.
package alu_pkg;

    localparam int ALU_OP_WIDTH   = 3;
    localparam int ALU_DATA_WIDTH = 8;
    // Requester IDs are carried in this many bits, so NUM_REQ may be at most 2**ALU_ID_WIDTH.
    localparam int ALU_ID_WIDTH   = 2;

    typedef logic [ALU_OP_WIDTH-1:0] alu_opcode_t;

    typedef struct packed {
        logic                    valid;
        logic [ALU_ID_WIDTH-1:0] id;
    } alu_tag_t;

    function automatic logic [ALU_ID_WIDTH-1:0] rr_next(
        input logic [ALU_ID_WIDTH-1:0] idx,
        input int                      num_req
    );
        return (int'(idx) == num_req - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr_i, wrapping.
// With ALU_ARB_PRIO0_EN defined, requester 0 wins outright and flags prio_win_o.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_oh_o,
    output logic [ID_WIDTH-1:0] grant_idx_o,
    output logic                any_grant_o,
    output logic                prio_win_o
);

    logic [ID_WIDTH-1:0] cand;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        prio_win_o  = 1'b0;
        cand        = '0;
`ifdef ALU_ARB_PRIO0_EN
        if (req_i[0]) begin
            grant_oh_o[0] = 1'b1;
            any_grant_o   = 1'b1;
            prio_win_o    = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(ptr_i) + i) % NUM_REQ);
            if (!any_grant_o && req_i[cand]) begin
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
                any_grant_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters; results are routed back by a tag pipe.
// Define ALU_ARB_PRIO0_EN to give requester 0 strict priority (handled in rr_arbiter).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
    parameter int OP_WIDTH    = ALU_OP_WIDTH,
    parameter int ALU_LATENCY = 1
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic [NUM_REQ-1:0]                req_valid_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    input  logic [NUM_REQ*OP_WIDTH-1:0]       req_opcode_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_b_in,
    output logic [NUM_REQ-1:0]                resp_valid_out,
    output logic [DATA_WIDTH-1:0]             resp_data_out,
    output logic [OP_WIDTH-1:0]               alu_opcode_out,
    output logic [DATA_WIDTH-1:0]             alu_input1_out,
    output logic [DATA_WIDTH-1:0]             alu_input2_out,
    input  logic [DATA_WIDTH-1:0]             alu_output_in,
    output logic [$clog2(ALU_LATENCY+1)-1:0]  inflight_out
);

    localparam int CNT_WIDTH = $clog2(ALU_LATENCY + 1);

    logic [ALU_ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
    alu_tag_t [ALU_LATENCY-1:0]         tag_q, tag_d;
    logic [CNT_WIDTH-1:0]               inflight_q, inflight_d;

    logic [NUM_REQ-1:0]                 req_masked;
    logic [NUM_REQ-1:0]                 grant_oh;
    logic [ALU_ID_WIDTH-1:0]            grant_idx;
    logic                               any_grant;
    logic                               prio_win;

    // Masking requests during reset keeps grants, ALU drive and the tag pipe quiet.
    assign req_masked = reset_in ? '0 : req_valid_in;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ALU_ID_WIDTH)
    ) u_rr_arbiter (
        .req_i       (req_masked),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant),
        .prio_win_o  (prio_win)
    );

    assign req_ready_out = grant_oh;

    always_comb begin
        alu_opcode_out = '0;
        alu_input1_out = '0;
        alu_input2_out = '0;
        if (any_grant) begin
            alu_opcode_out = req_opcode_in[int'(grant_idx)*OP_WIDTH +: OP_WIDTH];
            alu_input1_out = req_a_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            alu_input2_out = req_b_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        // A priority win must not disturb the rotation among the other requesters.
        if (any_grant && !prio_win) begin
            rr_ptr_d = rr_next(grant_idx, NUM_REQ);
        end
    end

    always_comb begin
        tag_d          = '0;
        tag_d[0].valid = any_grant;
        tag_d[0].id    = grant_idx;
        for (int i = 1; i < ALU_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            inflight_d = inflight_d + CNT_WIDTH'(tag_d[i].valid);
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rr_ptr_q   <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Gated by reset so a tag captured just before reset never produces a strobe.
    always_comb begin
        resp_valid_out = '0;
        resp_data_out  = '0;
        if (!reset_in && tag_q[ALU_LATENCY-1].valid) begin
            resp_valid_out[tag_q[ALU_LATENCY-1].id] = 1'b1;
            resp_data_out                           = alu_output_in;
        end
    end

    assign inflight_out = reset_in ? '0 : inflight_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model (ALU_LATENCY = 1).
// Expectations follow ALU_ARB_PRIO0_EN when the bench is built with it.
module tb_alu_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int OW  = 3;
    localparam int LAT = 1;
    localparam int CW  = $clog2(LAT + 1);

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*OW-1:0] req_op;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic [OW-1:0]    alu_op;
    logic [DW-1:0]    alu_in1;
    logic [DW-1:0]    alu_in2;
    logic [DW-1:0]    alu_out;
    logic [CW-1:0]    inflight;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .OP_WIDTH    (OW),
        .ALU_LATENCY (LAT)
    ) dut (
        .clock_in       (clk),
        .reset_in       (rst),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_opcode_in  (req_op),
        .req_a_in       (req_a),
        .req_b_in       (req_b),
        .resp_valid_out (resp_valid),
        .resp_data_out  (resp_data),
        .alu_opcode_out (alu_op),
        .alu_input1_out (alu_in1),
        .alu_input2_out (alu_in2),
        .alu_output_in  (alu_out),
        .inflight_out   (inflight)
    );

    // Registered ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, otherwise pass A.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out <= '0;
        end else begin
            case (alu_op)
                3'd0:    alu_out <= alu_in1 + alu_in2;
                3'd1:    alu_out <= alu_in1 - alu_in2;
                3'd2:    alu_out <= alu_in1 & alu_in2;
                3'd3:    alu_out <= alu_in1 | alu_in2;
                3'd4:    alu_out <= alu_in1 ^ alu_in2;
                default: alu_out <= alu_in1;
            endcase
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        req_op[i*OW +: OW] = op;
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_valid[i]       = 1'b1;
    endtask

    task automatic set_all();
        set_req(0, 3'd0, 8'd10,  8'd1);
        set_req(1, 3'd1, 8'd20,  8'd5);
        set_req(2, 3'd2, 8'hF0,  8'h3C);
        set_req(3, 3'd4, 8'hAA,  8'h0F);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_res [NR];
    int exp_id;
    int prev_id;
    logic [NR-1:0] exp_g;

    initial begin
        exp_res[0] = 8'd11;
        exp_res[1] = 8'd15;
        exp_res[2] = 8'h30;
        exp_res[3] = 8'hA5;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        set_all();

        // Reset held two cycles with every request valid
        repeat (2) begin
            @(negedge clk);
            check_val("rst_ready",    32'(req_ready),  32'h0);
            check_val("rst_resp",     32'(resp_valid), 32'h0);
            check_val("rst_data",     32'(resp_data),  32'h0);
            check_val("rst_alu_op",   32'(alu_op),     32'h0);
            check_val("rst_alu_in1",  32'(alu_in1),    32'h0);
            check_val("rst_alu_in2",  32'(alu_in2),    32'h0);
            check_val("rst_inflight", 32'(inflight),   32'h0);
        end
        next_cycle();
        rst = 1'b0;

        // Round-robin with all four valid
        prev_id = 0;
        for (int c = 0; c < 8; c++) begin
`ifdef ALU_ARB_PRIO0_EN
            exp_id = 0;
`else
            exp_id = c % NR;
`endif
            @(negedge clk);
            check_val("rr_grant", 32'(req_ready), 32'(1) << exp_id);
            if (c > 0) begin
                check_val("rr_resp",      32'(resp_valid), 32'(1) << prev_id);
                check_val("rr_data",      32'(resp_data),  32'(exp_res[prev_id]));
                check_val("rr_inflight",  32'(inflight),   32'h1);
            end else begin
                check_val("rr_resp0",     32'(resp_valid), 32'h0);
                check_val("rr_inflight0", 32'(inflight),   32'h0);
            end
            prev_id = exp_id;
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        check_val("rr_tail_grant", 32'(req_ready),  32'h0);
        check_val("rr_tail_aluop", 32'(alu_in1),    32'h0);
        check_val("rr_tail_resp",  32'(resp_valid), 32'(1) << prev_id);
        check_val("rr_tail_data",  32'(resp_data),  32'(exp_res[prev_id]));
        next_cycle();
        @(negedge clk);
        check_val("drain_resp",     32'(resp_valid), 32'h0);
        check_val("drain_data",     32'(resp_data),  32'h0);
        check_val("drain_inflight", 32'(inflight),   32'h0);

        // Single request: requester 2 ADD 5+3
        next_cycle();
        set_req(2, 3'd0, 8'd5, 8'd3);
        @(negedge clk);
        check_val("single_grant", 32'(req_ready), 32'h4);
        check_val("single_op",    32'(alu_op),    32'h0);
        check_val("single_in1",   32'(alu_in1),   32'd5);
        check_val("single_in2",   32'(alu_in2),   32'd3);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_val("single_resp",     32'(resp_valid), 32'h4);
        check_val("single_data",     32'(resp_data),  32'd8);
        check_val("single_inflight", 32'(inflight),   32'h1);

        // Idle gap: grant 1, two idle cycles, then 0 and 3
        next_cycle();
        set_req(1, 3'd1, 8'd20, 8'd5);
        @(negedge clk);
        check_val("gap_grant1", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_val("gap_idle1",  32'(req_ready),  32'h0);
        check_val("gap_resp1",  32'(resp_valid), 32'h2);
        check_val("gap_data1",  32'(resp_data),  32'd15);
        next_cycle();
        @(negedge clk);
        check_val("gap_idle2",  32'(req_ready),  32'h0);
        check_val("gap_resp_none", 32'(resp_valid), 32'h0);
        next_cycle();
        set_req(0, 3'd0, 8'd10, 8'd1);
        set_req(3, 3'd4, 8'hAA, 8'h0F);
`ifdef ALU_ARB_PRIO0_EN
        exp_g = 4'b0001;
`else
        exp_g = 4'b1000;
`endif
        @(negedge clk);
        check_val("gap_first", 32'(req_ready), 32'(exp_g));
        next_cycle();
        @(negedge clk);
        check_val("gap_second", 32'(req_ready),  32'h1);
        check_val("gap_resp2",  32'(resp_valid), 32'(exp_g));
        check_val("gap_data2",  32'(resp_data),  exp_g[3] ? 32'hA5 : 32'd11);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_val("gap_resp3", 32'(resp_valid), 32'h1);
        check_val("gap_data3", 32'(resp_data),  32'd11);

        // Reset mid-flight: requester 1 ADD 1+1, then reset
        next_cycle();
        set_req(1, 3'd0, 8'd1, 8'd1);
        @(negedge clk);
        check_val("mid_grant", 32'(req_ready), 32'h2);
        check_val("mid_in1",   32'(alu_in1),   32'd1);
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check_val("mid_resp_rst",     32'(resp_valid), 32'h0);
        check_val("mid_data_rst",     32'(resp_data),  32'h0);
        check_val("mid_inflight_rst", 32'(inflight),   32'h0);
        next_cycle();
        @(negedge clk);
        check_val("mid_resp_rst2", 32'(resp_valid), 32'h0);
        next_cycle();
        rst = 1'b0;
        set_all();
        @(negedge clk);
        check_val("mid_ptr0",     32'(req_ready),  32'h1);
        check_val("mid_resp_post", 32'(resp_valid), 32'h0);
        check_val("mid_inflight_post", 32'(inflight), 32'h0);

        // Requesters 0 and 2 contending (strict priority when built with it)
        next_cycle();
        req_valid = 4'b0100;
        @(negedge clk);
        check_val("prio_pre", 32'(req_ready), 32'h4);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            req_valid = 4'b0101;
`ifdef ALU_ARB_PRIO0_EN
            exp_g = 4'b0001;
`else
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
            @(negedge clk);
            check_val("prio_grant", 32'(req_ready), 32'(exp_g));
        end
        next_cycle();
        req_valid = 4'b1110;
        @(negedge clk);
        check_val("prio_ptr_kept", 32'(req_ready), 32'h8);

        next_cycle();
        req_valid = '0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
